// File: rtl/eth_vlg_ram_pkg.sv
// Shared types and helpers for the eth_vlg dual-port RAM and its clear sequencer.
// Optional parity storage is enabled by defining ETH_VLG_RAM_PARITY_EN.
package eth_vlg_ram_pkg;

  typedef enum logic {WRITE_FIRST, READ_FIRST} rdw_mode_t;
  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;

  localparam int MAX_BW = 64;

  // Even parity over one lane; narrower lanes are zero-extended by the caller.
  function automatic logic lane_parity(input logic [MAX_BW-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/eth_vlg_ram_clr.sv
// Clear sequencer: sweeps every address once, writing zero, while holding busy.
// The state is visible as busy (busy == state is CLR_RUN).
module eth_vlg_ram_clr
  import eth_vlg_ram_pkg::*;
#(
  parameter int AW       = 16,
  parameter bit INIT_CLR = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_a
);

  localparam logic [AW-1:0] CNT_LAST  = '1;
  localparam clr_state_t    RST_STATE = INIT_CLR ? CLR_RUN : CLR_IDLE;

  clr_state_t    state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Termination is by compare with the last address, so the sweep length never depends on wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLR_IDLE: begin
        if (clr_req) begin
          state_nxt = CLR_RUN;
          cnt_nxt   = '0;
        end
      end
      CLR_RUN: begin
        if (cnt == CNT_LAST) begin
          state_nxt = CLR_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = CLR_IDLE;
    endcase
  end

  assign busy   = (state == CLR_RUN);
  assign clr_we = busy;
  assign clr_a  = cnt;

endmodule

// File: rtl/eth_vlg_ram_dp.sv
// True dual-port single-clock RAM with byte enables, selectable read-during-write, optional
// output register and hardware clear. Define ETH_VLG_RAM_PARITY_EN for per-lane even parity.
module eth_vlg_ram_dp
  import eth_vlg_ram_pkg::*;
#(
  parameter int        AW       = 16,
  parameter int        DW       = 32,
  parameter int        BW       = 8,
  parameter rdw_mode_t RDW_MODE = WRITE_FIRST,
  parameter bit        OUT_REG  = 1'b0,
  parameter bit        INIT_CLR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  output logic             busy,
  input  logic             a_en,
  input  logic             a_we,
  input  logic [DW/BW-1:0] a_be,
  input  logic [AW-1:0]    a_a,
  input  logic [DW-1:0]    a_d,
  input  logic             a_inj,
  output logic [DW-1:0]    a_q,
  output logic             a_qv,
  output logic             a_perr,
  input  logic             b_en,
  input  logic             b_we,
  input  logic [DW/BW-1:0] b_be,
  input  logic [AW-1:0]    b_a,
  input  logic [DW-1:0]    b_d,
  input  logic             b_inj,
  output logic [DW-1:0]    b_q,
  output logic             b_qv,
  output logic             b_perr
);

  localparam int NB = DW / BW;
`ifdef ETH_VLG_RAM_PARITY_EN
  localparam int LW = BW + 1;
`else
  localparam int LW = BW;
`endif
  localparam int SW = NB * LW;

  logic [SW-1:0] mem [0:(2**AW)-1];

  logic          clr_we;
  logic [AW-1:0] clr_a;
  logic          a_acc, b_acc, a_wr, b_wr;
  logic [SW-1:0] a_old, b_old, a_new, b_new, a_msk, b_msk;
  logic [SW-1:0] a_mrg, b_mrg, a_base, a_store, a_view, b_view;
  logic [DW-1:0] a_rdat, b_rdat;
  logic [NB-1:0] a_lerr, b_lerr;
  logic [DW-1:0] a_q1, b_q1;
  logic          a_qv1, b_qv1, a_pe1, b_pe1;

  eth_vlg_ram_clr #(
    .AW       (AW),
    .INIT_CLR (INIT_CLR)
  ) u_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_a   (clr_a)
  );

  assign a_acc = a_en & ~busy;
  assign b_acc = b_en & ~busy;
  assign a_wr  = a_acc & a_we;
  assign b_wr  = b_acc & b_we;
  assign a_old = mem[a_a];
  assign b_old = mem[b_a];

  for (genvar i = 0; i < NB; i++) begin : g_lane
`ifdef ETH_VLG_RAM_PARITY_EN
    assign a_new[i*LW +: LW] = {lane_parity(MAX_BW'(a_d[i*BW +: BW])) ^ a_inj, a_d[i*BW +: BW]};
    assign b_new[i*LW +: LW] = {lane_parity(MAX_BW'(b_d[i*BW +: BW])) ^ b_inj, b_d[i*BW +: BW]};
    assign a_lerr[i] = lane_parity(MAX_BW'(a_view[i*LW +: BW])) ^ a_view[i*LW+BW];
    assign b_lerr[i] = lane_parity(MAX_BW'(b_view[i*LW +: BW])) ^ b_view[i*LW+BW];
`else
    assign a_new[i*LW +: LW] = a_d[i*BW +: BW];
    assign b_new[i*LW +: LW] = b_d[i*BW +: BW];
    assign a_lerr[i] = 1'b0;
    assign b_lerr[i] = 1'b0;
`endif
    assign a_msk[i*LW +: LW]  = {LW{a_wr & a_be[i]}};
    assign b_msk[i*LW +: LW]  = {LW{b_wr & b_be[i]}};
    assign a_rdat[i*BW +: BW] = a_view[i*LW +: BW];
    assign b_rdat[i*BW +: BW] = b_view[i*LW +: BW];
  end

`ifndef ETH_VLG_RAM_PARITY_EN
  logic unused_inj;
  assign unused_inj = a_inj | b_inj;
`endif

  assign a_mrg = (a_old & ~a_msk) | (a_new & a_msk);
  assign b_mrg = (b_old & ~b_msk) | (b_new & b_msk);

  // On a same-address double write A merges on top of B, so B keeps its non-overlapping lanes.
  assign a_base  = (b_wr && (b_a == a_a)) ? b_mrg : a_old;
  assign a_store = (a_base & ~a_msk) | (a_new & a_msk);

  // Same-port view only; the other port's write is never visible in this cycle's read.
  assign a_view = (RDW_MODE == WRITE_FIRST) ? a_mrg : a_old;
  assign b_view = (RDW_MODE == WRITE_FIRST) ? b_mrg : b_old;

  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_a] <= '0;
    if (b_wr)   mem[b_a]   <= b_mrg;
    if (a_wr)   mem[a_a]   <= a_store;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q1  <= '0;
      a_qv1 <= 1'b0;
      a_pe1 <= 1'b0;
      b_q1  <= '0;
      b_qv1 <= 1'b0;
      b_pe1 <= 1'b0;
    end else begin
      a_qv1 <= a_acc;
      b_qv1 <= b_acc;
      a_pe1 <= a_acc & (|a_lerr);
      b_pe1 <= b_acc & (|b_lerr);
      if (a_acc) a_q1 <= a_rdat;
      if (b_acc) b_q1 <= b_rdat;
    end
  end

  if (OUT_REG) begin : g_oreg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q    <= '0;
        a_qv   <= 1'b0;
        a_perr <= 1'b0;
        b_q    <= '0;
        b_qv   <= 1'b0;
        b_perr <= 1'b0;
      end else begin
        a_qv   <= a_qv1;
        b_qv   <= b_qv1;
        a_perr <= a_pe1;
        b_perr <= b_pe1;
        if (a_qv1) a_q <= a_q1;
        if (b_qv1) b_q <= b_q1;
      end
    end
  end else begin : g_noreg
    assign a_q    = a_q1;
    assign a_qv   = a_qv1;
    assign a_perr = a_pe1;
    assign b_q    = b_q1;
    assign b_qv   = b_qv1;
    assign b_perr = b_pe1;
  end

endmodule

// File: tb/tb_eth_vlg_ram_dp.sv
// Bench for eth_vlg_ram_dp: a WRITE_FIRST/no-out-reg instance and a READ_FIRST/out-reg instance
// share stimulus and are scored against a word/lane-level memory model.
module tb_eth_vlg_ram_dp;
  import eth_vlg_ram_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int BW    = 8;
  localparam int NB    = DW / BW;
  localparam int DEPTH = 2 ** AW;
`ifdef ETH_VLG_RAM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          clr_req;
  logic          a_en, a_we, a_inj, b_en, b_we, b_inj;
  logic [NB-1:0] a_be, b_be;
  logic [AW-1:0] a_a, b_a;
  logic [DW-1:0] a_d, b_d;
  logic          busy0, busy1;
  logic [DW-1:0] a_q0, b_q0, a_q1, b_q1;
  logic          a_qv0, b_qv0, a_qv1, b_qv1;
  logic          a_perr0, b_perr0, a_perr1, b_perr1;

  eth_vlg_ram_dp #(
    .AW(AW), .DW(DW), .BW(BW), .RDW_MODE(WRITE_FIRST), .OUT_REG(1'b0), .INIT_CLR(1'b1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy0),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_a(a_a), .a_d(a_d), .a_inj(a_inj),
    .a_q(a_q0), .a_qv(a_qv0), .a_perr(a_perr0),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_a(b_a), .b_d(b_d), .b_inj(b_inj),
    .b_q(b_q0), .b_qv(b_qv0), .b_perr(b_perr0)
  );

  eth_vlg_ram_dp #(
    .AW(AW), .DW(DW), .BW(BW), .RDW_MODE(READ_FIRST), .OUT_REG(1'b1), .INIT_CLR(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy1),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_a(a_a), .a_d(a_d), .a_inj(a_inj),
    .a_q(a_q1), .a_qv(a_qv1), .a_perr(a_perr1),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_a(b_a), .b_d(b_d), .b_inj(b_inj),
    .b_q(b_q1), .b_qv(b_qv1), .b_perr(b_perr1)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] mem_m [DEPTH];
  logic [NB-1:0] bad_m [DEPTH];
  bit            busy_m;
  int            rem;
  int            cyc;
  int            total;
  int            bad;
  // entry = {due cycle[31:0], perr, q}; index = dut*2 + port
  logic [64:0]   exp_q [4][$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = '0;
      bad_m[i] = '0;
    end
  endtask

  // Response of one access: old word, or with WRITE_FIRST the old word overlaid by own lanes.
  function automatic logic [DW:0] port_resp(input bit wf, input logic we, input logic [NB-1:0] be,
                                            input logic [AW-1:0] adr, input logic [DW-1:0] d,
                                            input logic inj);
    logic [DW-1:0] w;
    logic [NB-1:0] bd;
    w  = mem_m[adr];
    bd = bad_m[adr];
    if (wf && we)
      for (int i = 0; i < NB; i++)
        if (be[i]) begin
          w[i*BW +: BW] = d[i*BW +: BW];
          bd[i]         = inj;
        end
    return {PAR_EN ? (|bd) : 1'b0, w};
  endfunction

  task automatic model_write(input logic [NB-1:0] be, input logic [AW-1:0] adr,
                             input logic [DW-1:0] d, input logic inj);
    for (int i = 0; i < NB; i++)
      if (be[i]) begin
        mem_m[adr][i*BW +: BW] = d[i*BW +: BW];
        bad_m[adr][i]          = inj;
      end
  endtask

  task automatic check_port(input int id, input logic qv, input logic [DW-1:0] q,
                            input logic perr);
    logic        exp_v;
    logic [64:0] e;
    exp_v = 1'b0;
    e     = '0;
    if (exp_q[id].size() > 0 && exp_q[id][0][64:33] == 32'(cyc)) begin
      exp_v = 1'b1;
      e     = exp_q[id].pop_front();
    end
    check($sformatf("qv[%0d]", id), 64'(qv), 64'(exp_v));
    if (exp_v && qv) begin
      check($sformatf("q[%0d]", id), 64'(q), 64'(e[31:0]));
      check($sformatf("perr[%0d]", id), 64'(perr), 64'(e[32]));
    end
  endtask

  // One clock: model the edge with the inputs as driven, then score outputs on the falling edge.
  task automatic cycle();
    logic [DW:0] r;
    @(posedge clk);
    cyc++;
    if (!busy_m) begin
      for (int d = 0; d < 2; d++) begin
        if (a_en) begin
          r = port_resp(d == 0, a_we, a_be, a_a, a_d, a_inj);
          exp_q[d*2].push_back({32'(cyc + d), r});
        end
        if (b_en) begin
          r = port_resp(d == 0, b_we, b_be, b_a, b_d, b_inj);
          exp_q[d*2+1].push_back({32'(cyc + d), r});
        end
      end
      if (b_en && b_we) model_write(b_be, b_a, b_d, b_inj);
      if (a_en && a_we) model_write(a_be, a_a, a_d, a_inj);
      if (clr_req) begin
        busy_m = 1'b1;
        rem    = DEPTH;
        model_clear();
      end
    end else begin
      rem--;
      if (rem == 0) busy_m = 1'b0;
    end
    @(negedge clk);
    check("busy0", 64'(busy0), 64'(busy_m));
    check("busy1", 64'(busy1), 64'(busy_m));
    check_port(0, a_qv0, a_q0, a_perr0);
    check_port(1, b_qv0, b_q0, b_perr0);
    check_port(2, a_qv1, a_q1, a_perr1);
    check_port(3, b_qv1, b_q1, b_perr1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    clr_req = 1'b0;
    a_en = 1'b0; a_we = 1'b0; a_be = '0; a_a = '0; a_d = '0; a_inj = 1'b0;
    b_en = 1'b0; b_we = 1'b0; b_be = '0; b_a = '0; b_d = '0; b_inj = 1'b0;
  endtask

  task automatic acc_a(input logic we, input logic [NB-1:0] be, input logic [AW-1:0] adr,
                       input logic [DW-1:0] d, input logic inj);
    a_en = 1'b1; a_we = we; a_be = be; a_a = adr; a_d = d; a_inj = inj;
  endtask

  task automatic acc_b(input logic we, input logic [NB-1:0] be, input logic [AW-1:0] adr,
                       input logic [DW-1:0] d, input logic inj);
    b_en = 1'b1; b_we = we; b_be = be; b_a = adr; b_d = d; b_inj = inj;
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) cycle();
  endtask

  task automatic do_reset(input int hold);
    idle();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    repeat (hold) @(posedge clk);
    @(negedge clk);
    check("rst_busy0", 64'(busy0), 64'(1'b1));
    check("rst_busy1", 64'(busy1), 64'(1'b1));
    check("rst_q", 64'(a_q0 | b_q0 | a_q1 | b_q1), 64'(0));
    check("rst_qv", 64'({a_qv0, b_qv0, a_qv1, b_qv1}), 64'(0));
    check("rst_perr", 64'({a_perr0, b_perr0, a_perr1, b_perr1}), 64'(0));
    rst_n  = 1'b1;
    busy_m = 1'b1;
    rem    = DEPTH;
    model_clear();
  endtask

  task automatic random_traffic(input int n);
    for (int k = 0; k < n; k++) begin
      idle();
      if ($urandom_range(0, 3) != 0)
        acc_a($urandom_range(0, 1) == 1, NB'($urandom_range(0, 15)), AW'($urandom_range(0, DEPTH-1)),
              $urandom, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) != 0)
        acc_b($urandom_range(0, 1) == 1, NB'($urandom_range(0, 15)), AW'($urandom_range(0, DEPTH-1)),
              $urandom, $urandom_range(0, 7) == 0);
      clr_req = ($urandom_range(0, 149) == 0);
      cycle();
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    total = 0;
    bad   = 0;
    cyc   = 0;
    do_reset(3);

    // Initial clear: busy must last exactly the depth, counted independently of the model.
    n = 0;
    while (busy0 && n < 4 * DEPTH) begin
      cycle();
      n++;
    end
    check("init_busy_len", 64'(n), 64'(DEPTH));

    for (int i = 0; i < DEPTH; i++) begin
      idle();
      acc_a(1'b0, '0, AW'(i), '0, 1'b0);
      acc_b(1'b0, '0, AW'(DEPTH - 1 - i), '0, 1'b0);
      cycle();
    end
    drain(3);

    // Same-cycle double write to a cleared word.
    idle(); acc_a(1'b1, 4'b0011, 4'd3, 32'hAAAAAAAA, 1'b0);
            acc_b(1'b1, 4'b0110, 4'd3, 32'hBBBBBBBB, 1'b0); cycle();
    idle(); acc_a(1'b0, '0, 4'd3, '0, 1'b0); acc_b(1'b0, '0, 4'd3, '0, 1'b0); cycle();
    drain(3);

    // Partial-lane update, then cross-port read.
    idle(); acc_a(1'b1, 4'b1111, 4'd5, 32'hDEADBEEF, 1'b0); cycle();
    idle(); acc_a(1'b1, 4'b0010, 4'd5, 32'h0000AA00, 1'b0); cycle();
    idle(); acc_b(1'b0, '0, 4'd5, '0, 1'b0); cycle();
    drain(3);

    // Read-during-write on the same port, plus a cross-port read of the word being written.
    idle(); acc_a(1'b1, 4'b1111, 4'd7, 32'hDEADBEEF, 1'b0); cycle();
    idle(); acc_a(1'b1, 4'b1111, 4'd7, 32'h11223344, 1'b0); acc_b(1'b0, '0, 4'd7, '0, 1'b0); cycle();
    idle(); acc_a(1'b1, 4'b0000, 4'd7, 32'h55555555, 1'b0); cycle();
    drain(3);

    // Parity injection, then clean rewrite.
    idle(); acc_a(1'b1, 4'b1111, 4'd9, 32'hCAFEF00D, 1'b1); cycle();
    idle(); acc_b(1'b0, '0, 4'd9, '0, 1'b0); cycle();
    idle(); acc_a(1'b1, 4'b1111, 4'd9, 32'hCAFEF00D, 1'b0); cycle();
    idle(); acc_b(1'b0, '0, 4'd9, '0, 1'b0); cycle();
    drain(3);

    random_traffic(800);
    drain(4);
    while (busy_m) cycle();

    // Clear requested in traffic, then reset partway through the sweep.
    random_traffic(4);
    idle(); acc_a(1'b1, 4'b1111, 4'd2, 32'h12345678, 1'b0); clr_req = 1'b1; cycle();
    random_traffic(8);
    do_reset(2);
    n = 0;
    while (busy0 && n < 4 * DEPTH) begin
      random_traffic(1);
      n++;
    end
    check("rst_busy_len", 64'(n), 64'(DEPTH));
    random_traffic(200);
    drain(4);
    while (busy_m) cycle();
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      acc_b(1'b0, '0, AW'(i), '0, 1'b0);
      cycle();
    end
    drain(4);

    for (int i = 0; i < 4; i++) check($sformatf("leftover[%0d]", i), 64'(exp_q[i].size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
